// File: rtl/xbar_pkg.sv
// Shared types for the crossbar frame path: port count, packet width,
// the header+payload frame struct and the serializer state encoding.
package xbar_pkg;

  localparam int ports        = 8;
  localparam int packet_width = 8;

  typedef logic [packet_width-1:0] packet;

  // Header sits in the upper bits so a packed array of these lines up
  // with the in_frame bus of the serializer.
  typedef struct packed {
    packet header;
    packet payload;
  } full_packet;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PLD  = 2'd2,
    PAR  = 2'd3
  } ser_state_e;

endpackage

// File: rtl/xbar_bit_tick.sv
// Free-running bit-period divider: bit_tick is high during the last clk
// cycle of every CLK_DIV-cycle period, counting from the first cycle out
// of reset.
module xbar_bit_tick #(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  output logic bit_tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] last_cnt = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..CLK_DIV-1 and wrap; cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (cnt == last_cnt) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign bit_tick = (cnt == last_cnt);

endmodule

// File: rtl/xbar_frame_serializer.sv
// Crossbar frame serializer: takes one parallel frame (header+payload per
// port) through a 1-entry holding register and shifts every port's header
// then payload MSB-first onto its own serial lane, one bit per bit tick.
// All lanes shift in lockstep and share header_present.
// Optional build macro XBAR_SER_PARITY_EN appends an even-parity bit per
// lane after each header byte and each payload byte.
//
// Handshake: a frame transfers on a clk edge where in_valid && in_ready.
// in_ready is a register (no combinational path from in_valid); it drops
// on the accept edge and rises again on the edge after the holding
// register is unloaded into the shifters. in_frame is ignored whenever no
// transfer happens.
module xbar_frame_serializer
  import xbar_pkg::*;
#(
  parameter int PORTS   = ports,
  parameter int WIDTH   = packet_width,
  parameter int CLK_DIV = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PORTS*2*WIDTH-1:0] in_frame,
  output logic [PORTS-1:0]         serial_out,
  output logic                     bit_tick,
  output logic                     header_present,
  output logic                     frame_done,
  output logic                     busy
);

  localparam int FW = 2 * WIDTH;
  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] top_idx = IW'(WIDTH - 1);

  ser_state_e          state;
  logic [IW-1:0]       bit_idx;
  logic                hold_valid;
  logic [PORTS*FW-1:0] hold;

  logic accept;
  logic load;
  logic shift;
  logic new_byte;
  logic clear;
  logic done;
`ifdef XBAR_SER_PARITY_EN
  logic emit_par;
  logic hdr_phase;
`endif

  xbar_bit_tick #(.CLK_DIV(CLK_DIV)) u_bit_tick (
    .clk      (clk),
    .rst      (rst),
    .bit_tick (bit_tick)
  );

  assign accept = in_valid && in_ready;
  assign busy   = (state != IDLE) || hold_valid;

  // Decode what the lanes do on this edge; nothing moves except on bit_tick.
  always_comb begin
    load     = 1'b0;
    shift    = 1'b0;
    new_byte = 1'b0;
    clear    = 1'b0;
    done     = 1'b0;
`ifdef XBAR_SER_PARITY_EN
    emit_par = 1'b0;
`endif
    if (bit_tick) begin
      case (state)
        IDLE: load = hold_valid;
        HDR: begin
          if (bit_idx != '0) begin
            shift = 1'b1;
          end else begin
`ifdef XBAR_SER_PARITY_EN
            emit_par = 1'b1;
`else
            shift    = 1'b1;
            new_byte = 1'b1;
`endif
          end
        end
        PLD: begin
          if (bit_idx != '0) begin
            shift = 1'b1;
          end else begin
`ifdef XBAR_SER_PARITY_EN
            emit_par = 1'b1;
`else
            done     = 1'b1;
`endif
          end
        end
`ifdef XBAR_SER_PARITY_EN
        PAR: begin
          if (hdr_phase) begin
            shift    = 1'b1;
            new_byte = 1'b1;
          end else begin
            done = 1'b1;
          end
        end
`endif
        default: ;
      endcase
      // End of frame: chain straight into a waiting frame, else go quiet.
      if (done) begin
        load  = hold_valid;
        clear = !hold_valid;
      end
    end
  end

  // Holding register, handshake and frame sequencing FSM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      bit_idx        <= '0;
      hold_valid     <= 1'b0;
      hold           <= '0;
      in_ready       <= 1'b0;
      header_present <= 1'b0;
      frame_done     <= 1'b0;
`ifdef XBAR_SER_PARITY_EN
      hdr_phase      <= 1'b0;
`endif
    end else begin
      frame_done <= done;
      in_ready   <= !hold_valid && !accept;
      if (accept) begin
        hold       <= in_frame;
        hold_valid <= 1'b1;
      end else if (load) begin
        hold_valid <= 1'b0;
      end
      if (load) begin
        state          <= HDR;
        bit_idx        <= top_idx;
        header_present <= 1'b1;
`ifdef XBAR_SER_PARITY_EN
        hdr_phase      <= 1'b1;
`endif
      end else if (clear) begin
        state          <= IDLE;
        header_present <= 1'b0;
`ifdef XBAR_SER_PARITY_EN
      end else if (emit_par) begin
        // header_present is left as-is: high through the header parity bit.
        state <= PAR;
`endif
      end else if (shift) begin
        if (new_byte) begin
          state          <= PLD;
          bit_idx        <= top_idx;
          header_present <= 1'b0;
`ifdef XBAR_SER_PARITY_EN
          hdr_phase      <= 1'b0;
`endif
        end else begin
          bit_idx <= bit_idx - 1'b1;
        end
      end
    end
  end

  for (genvar p = 0; p < PORTS; p++) begin : g_lane
    logic [FW-1:0] sr;
    logic          lane;
`ifdef XBAR_SER_PARITY_EN
    logic          par_acc;
`endif

    // Per-port shifter: the lane register holds the bit on the wire, sr
    // holds the not-yet-sent bits MSB-aligned.
    always_ff @(posedge clk) begin
      if (!rst) begin
        sr      <= '0;
        lane    <= 1'b0;
`ifdef XBAR_SER_PARITY_EN
        par_acc <= 1'b0;
`endif
      end else if (load) begin
        lane    <= hold[p*FW + FW-1];
        sr      <= {hold[p*FW +: FW-1], 1'b0};
`ifdef XBAR_SER_PARITY_EN
        par_acc <= hold[p*FW + FW-1];
`endif
      end else if (clear) begin
        lane <= 1'b0;
`ifdef XBAR_SER_PARITY_EN
      end else if (emit_par) begin
        lane <= par_acc;
`endif
      end else if (shift) begin
        lane    <= sr[FW-1];
        sr      <= {sr[FW-2:0], 1'b0};
`ifdef XBAR_SER_PARITY_EN
        par_acc <= new_byte ? sr[FW-1] : (par_acc ^ sr[FW-1]);
`endif
      end
    end

    assign serial_out[p] = lane;
  end

endmodule

// File: tb/tb_xbar_frame_serializer.sv
// Directed bench for xbar_frame_serializer (PORTS=8, WIDTH=8, CLK_DIV=10).
// Outputs are sampled on the falling edge; inputs change on the falling edge.
`timescale 1ns/1ps
module tb_xbar_frame_serializer;

  localparam int PORTS   = 8;
  localparam int WIDTH   = 8;
  localparam int CLK_DIV = 10;
  localparam int FW      = 2 * WIDTH;
`ifdef XBAR_SER_PARITY_EN
  localparam int BITS = 18;
`else
  localparam int BITS = 16;
`endif
  localparam int FLEN = BITS * CLK_DIV;
  localparam int HLEN = (BITS / 2) * CLK_DIV;
  localparam int HN   = 512;

  // ---------------- clock / reset / DUT ----------------
  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                in_valid = 1'b0;
  logic [PORTS*FW-1:0] in_frame = '0;
  logic                in_ready;
  logic [PORTS-1:0]    serial_out;
  logic                bit_tick;
  logic                header_present;
  logic                frame_done;
  logic                busy;

  always #5 clk = ~clk;

  xbar_frame_serializer #(.PORTS(PORTS), .WIDTH(WIDTH), .CLK_DIV(CLK_DIV)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_frame       (in_frame),
    .serial_out     (serial_out),
    .bit_tick       (bit_tick),
    .header_present (header_present),
    .frame_done     (frame_done),
    .busy           (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Per-cycle history of the outputs, index 0 = first sample taken.
  logic [PORTS-1:0] lane_h [HN];
  logic             hp_h   [HN];
  logic             fd_h   [HN];
  logic             rdy_h  [HN];

  // Expected wire order for one port: header MSB first, then payload.
  function automatic logic [BITS-1:0] ser_seq(input logic [7:0] h, input logic [7:0] p);
`ifdef XBAR_SER_PARITY_EN
    return {h, ^h, p, ^p};
`else
    return {h, p};
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic record(input int n);
    for (int k = 0; k < n; k++) begin
      lane_h[k] = serial_out;
      hp_h[k]   = header_present;
      fd_h[k]   = frame_done;
      rdy_h[k]  = in_ready;
      @(negedge clk);
    end
  endtask

  // Offer one frame; returns at the falling edge after the accept edge.
  task automatic offer(input logic [PORTS*FW-1:0] f, output bit ok);
    ok       = 1'b0;
    in_valid = 1'b1;
    in_frame = f;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (in_ready === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  function automatic int first_hp(input int n);
    for (int k = 0; k < n; k++) if (hp_h[k] === 1'b1) return k;
    return -1;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    int c;
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({serial_out, header_present, frame_done, in_ready, busy, bit_tick} !== 13'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want all zero",
               {serial_out, header_present, frame_done, in_ready, busy, bit_tick});
    end
    rst = 1'b1;
    c = 0;
    while (bit_tick !== 1'b1 && c < 40) begin
      @(negedge clk);
      c++;
    end
    n_cmp++;
    if (c + 1 != CLK_DIV) begin
      n_bad++;
      $display("FAIL reset_first_tick: tick edge %0d cycles after release, want %0d", c + 1, CLK_DIV);
    end
    n_cmp++;
    if ({in_ready, busy} !== 2'b10) begin
      n_bad++;
      $display("FAIL reset_idle_handshake: in_ready,busy = %b want 10", {in_ready, busy});
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [PORTS*FW-1:0] f;
    bit ok;
    int seen_fd, seen_act;
    f = {PORTS{16'hFFFF}};
    offer(f, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL midrst_offer: accepted=%0d want 1", ok); end
    record(60);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({serial_out, header_present, frame_done, in_ready, busy, bit_tick} !== 13'b0) begin
      n_bad++;
      $display("FAIL midrst_outputs: got %b want all zero",
               {serial_out, header_present, frame_done, in_ready, busy, bit_tick});
    end
    seen_fd = 0;
    repeat (2) begin
      @(negedge clk);
      if (frame_done !== 1'b0) seen_fd++;
    end
    rst = 1'b1;
    record(200);
    seen_act = 0;
    for (int k = 0; k < 200; k++) begin
      if (fd_h[k] !== 1'b0) seen_fd++;
      if (lane_h[k] !== '0 || hp_h[k] !== 1'b0) seen_act++;
    end
    n_cmp++;
    if (seen_fd != 0) begin
      n_bad++;
      $display("FAIL midrst_no_done: frame_done seen %0d times want 0", seen_fd);
    end
    n_cmp++;
    if (seen_act != 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_dropped: %0d active cycles, busy=%b want 0 and 0", seen_act, busy);
    end
  endtask

  task automatic test_single();
    logic [PORTS*FW-1:0] f;
    logic [BITS-1:0]     exp0;
    bit ok;
    int s, errs, hp_cnt, fd_cnt, other;
`ifdef XBAR_SER_PARITY_EN
    exp0 = 18'b10100101_0_00111100_0;
`else
    exp0 = 16'b10100101_00111100;
`endif
    f = '0;
    f[0 +: 16] = {8'hA5, 8'h3C};
    offer(f, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL single_offer: accepted=%0d want 1", ok); end
    record(200);
    s = first_hp(200);
    n_cmp++;
    if (s < 1 || s > CLK_DIV) begin
      n_bad++;
      $display("FAIL single_latency: first bit after %0d cycles want 1..%0d", s, CLK_DIV);
    end
    if (s < 0) s = 0;
    for (int b = 0; b < BITS; b++) begin
      errs = 0;
      for (int c = 0; c < CLK_DIV; c++)
        if (lane_h[s + b*CLK_DIV + c][0] !== exp0[BITS-1-b]) errs++;
      n_cmp++;
      if (errs != 0) begin
        n_bad++;
        $display("FAIL single_lane0_bit%0d: wrong on %0d of %0d cycles, want %b",
                 b, errs, CLK_DIV, exp0[BITS-1-b]);
      end
    end
    hp_cnt = 0; fd_cnt = 0; other = 0;
    for (int k = 0; k < 200; k++) begin
      if (hp_h[k] === 1'b1) hp_cnt++;
      if (fd_h[k] === 1'b1) fd_cnt++;
      if (lane_h[k][PORTS-1:1] !== '0) other++;
    end
    n_cmp++;
    if (hp_cnt != HLEN || hp_h[s + HLEN - 1] !== 1'b1) begin
      n_bad++;
      $display("FAIL single_header_present: high %0d cycles want %0d contiguous", hp_cnt, HLEN);
    end
    n_cmp++;
    if (fd_cnt != 1 || fd_h[s + FLEN] !== 1'b1) begin
      n_bad++;
      $display("FAIL single_frame_done: %0d pulses, at end=%b want 1 pulse at cycle %0d",
               fd_cnt, fd_h[s + FLEN], s + FLEN);
    end
    n_cmp++;
    if (other != 0) begin
      n_bad++;
      $display("FAIL single_other_lanes: %0d nonzero cycles want 0", other);
    end
    errs = 0;
    for (int k = s + FLEN; k < 200; k++) if (lane_h[k] !== '0) errs++;
    n_cmp++;
    if (errs != 0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL single_idle_after: %0d nonzero lane cycles, busy=%b in_ready=%b want 0,0,1",
               errs, busy, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [PORTS*FW-1:0] fa, fb;
    logic [2*BITS-1:0]   exp0, exp1;
    bit ok_a, ok_b;
    int s, e0, e1, fd_cnt;
    fa = '0;
    fa[0 +: 16]  = {8'hA5, 8'h3C};
    fb = '0;
    fb[0 +: 16]  = {8'h5A, 8'hC3};
    fb[16 +: 16] = {8'h81, 8'h7E};
    exp0 = {ser_seq(8'hA5, 8'h3C), ser_seq(8'h5A, 8'hC3)};
    exp1 = {ser_seq(8'h00, 8'h00), ser_seq(8'h81, 8'h7E)};
    offer(fa, ok_a);
    fork
      record(400);
      offer(fb, ok_b);
    join
    n_cmp++;
    if (!ok_a || !ok_b) begin
      n_bad++;
      $display("FAIL b2b_offers: accepted A=%0d B=%0d want 1 1", ok_a, ok_b);
    end
    s = first_hp(400);
    if (s < 0) s = 0;
    e0 = 0; e1 = 0;
    for (int b = 0; b < 2*BITS; b++)
      for (int c = 0; c < CLK_DIV; c++) begin
        if (lane_h[s + b*CLK_DIV + c][0] !== exp0[2*BITS-1-b]) e0++;
        if (lane_h[s + b*CLK_DIV + c][1] !== exp1[2*BITS-1-b]) e1++;
      end
    n_cmp++;
    if (e0 != 0) begin n_bad++; $display("FAIL b2b_lane0: %0d wrong cycles want 0", e0); end
    n_cmp++;
    if (e1 != 0) begin n_bad++; $display("FAIL b2b_lane1: %0d wrong cycles want 0", e1); end
    fd_cnt = 0;
    for (int k = 0; k < 400; k++) if (fd_h[k] === 1'b1) fd_cnt++;
    n_cmp++;
    if (fd_cnt != 2 || fd_h[s + FLEN] !== 1'b1 || fd_h[s + 2*FLEN] !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_frame_done: %0d pulses, at %0d=%b at %0d=%b want 2 pulses %0d apart",
               fd_cnt, s + FLEN, fd_h[s + FLEN], s + 2*FLEN, fd_h[s + 2*FLEN], FLEN);
    end
    n_cmp++;
    if (hp_h[s + FLEN - 1] !== 1'b0 || hp_h[s + FLEN] !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_no_gap: header_present around switch %b%b want 01",
               hp_h[s + FLEN - 1], hp_h[s + FLEN]);
    end
    n_cmp++;
    if ({rdy_h[s], rdy_h[s+1], rdy_h[s+2], rdy_h[s+FLEN], rdy_h[s+FLEN+1]} !== 5'b01001) begin
      n_bad++;
      $display("FAIL b2b_in_ready: got %b want 01001",
               {rdy_h[s], rdy_h[s+1], rdy_h[s+2], rdy_h[s+FLEN], rdy_h[s+FLEN+1]});
    end
  endtask

  task automatic test_backpressure();
    logic [PORTS*FW-1:0] fa, fc;
    logic [PORTS*FW-1:0] junk [4];
    logic [BITS-1:0]     exp0, exp7;
    bit ok, got;
    int f, e0, e7;
    fa = '0;
    fa[0 +: 16]   = {8'hF0, 8'h0F};
    fc = '0;
    fc[0 +: 16]   = {8'hC3, 8'h96};
    fc[112 +: 16] = {8'h12, 8'h34};
    junk[0] = {PORTS*FW{1'b1}};
    junk[1] = {(PORTS*FW/2){2'b10}};
    junk[2] = {(PORTS*FW/2){2'b01}};
    junk[3] = {(PORTS*FW/8){8'h5F}};
    exp0 = ser_seq(8'hC3, 8'h96);
    exp7 = ser_seq(8'h12, 8'h34);
    offer(fa, ok);
    in_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      if (in_ready === 1'b1) begin
        in_frame = fc;
        @(posedge clk);
        got = 1'b1;
      end else begin
        in_frame = junk[i % 4];
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_frame = junk[0];
    n_cmp++;
    if (!ok || !got) begin
      n_bad++;
      $display("FAIL bp_offers: accepted A=%0d C=%0d want 1 1", ok, got);
    end
    record(400);
    f = 0;
    for (int k = 399; k >= 0; k--) if (fd_h[k] === 1'b1 && k < 300) f = k;
    e0 = 0; e7 = 0;
    for (int b = 0; b < BITS; b++)
      for (int c = 0; c < CLK_DIV; c++) begin
        if (lane_h[f + b*CLK_DIV + c][0] !== exp0[BITS-1-b]) e0++;
        if (lane_h[f + b*CLK_DIV + c][7] !== exp7[BITS-1-b]) e7++;
      end
    n_cmp++;
    if (e0 != 0 || e7 != 0) begin
      n_bad++;
      $display("FAIL bp_captured_value: lane0 %0d lane7 %0d wrong cycles from cycle %0d want 0 0",
               e0, e7, f);
    end
    n_cmp++;
    if (fd_h[f + FLEN] !== 1'b1 || hp_h[f] !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_second_frame: done at end=%b header_present at start=%b want 1 1",
               fd_h[f + FLEN], hp_h[f]);
    end
  endtask

  task automatic test_ports();
    logic [PORTS*FW-1:0] f;
    logic [BITS-1:0]     expk;
    bit ok;
    int s, errs;
    for (int k = 0; k < PORTS; k++) f[k*FW +: FW] = {8'(k), 8'(8'hFF - k)};
    offer(f, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL ports_offer: accepted=%0d want 1", ok); end
    record(200);
    s = first_hp(200);
    if (s < 0) s = 0;
    for (int p = 0; p < PORTS; p++) begin
      expk = ser_seq(8'(p), 8'(8'hFF - p));
      errs = 0;
      for (int b = 0; b < BITS; b++)
        for (int c = 0; c < CLK_DIV; c++)
          if (lane_h[s + b*CLK_DIV + c][p] !== expk[BITS-1-b]) errs++;
      n_cmp++;
      if (errs != 0) begin
        n_bad++;
        $display("FAIL ports_lane%0d: %0d wrong cycles want 0 (seq %b)", p, errs, expk);
      end
    end
  endtask

`ifdef XBAR_SER_PARITY_EN
  task automatic test_parity();
    logic [PORTS*FW-1:0] f;
    bit ok;
    int s;
    f = '0;
    f[0 +: 16] = {8'h07, 8'h03};
    offer(f, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL parity_offer: accepted=%0d want 1", ok); end
    record(220);
    s = first_hp(220);
    if (s < 0) s = 0;
    n_cmp++;
    if (lane_h[s + 8*CLK_DIV][0] !== 1'b1 || lane_h[s + 9*CLK_DIV - 1][0] !== 1'b1 ||
        hp_h[s + 9*CLK_DIV - 1] !== 1'b1) begin
      n_bad++;
      $display("FAIL parity_header_bit: lane=%b header_present=%b want 1 1",
               lane_h[s + 8*CLK_DIV][0], hp_h[s + 9*CLK_DIV - 1]);
    end
    n_cmp++;
    if (lane_h[s + 17*CLK_DIV][0] !== 1'b0 || lane_h[s + 16*CLK_DIV + 5][0] !== 1'b1) begin
      n_bad++;
      $display("FAIL parity_payload_bit: parity=%b last data bit=%b want 0 1",
               lane_h[s + 17*CLK_DIV][0], lane_h[s + 16*CLK_DIV + 5][0]);
    end
    n_cmp++;
    if (fd_h[s + 180] !== 1'b1 || fd_h[s + 179] !== 1'b0) begin
      n_bad++;
      $display("FAIL parity_frame_len: done at 180=%b at 179=%b want 1 0",
               fd_h[s + 180], fd_h[s + 179]);
    end
  endtask
`endif

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_reset_mid_frame();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_ports();
`ifdef XBAR_SER_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
